// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchroniser plus stability counter; a bit's debounced value
// follows its synchronised input only after COUNT_MAX consecutive differing cycles.
module switch_debouncer #(
    parameter int WIDTH     = 5,
    parameter int COUNT_MAX = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed
);

    localparam int CW = $clog2(COUNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_MAX - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_ACCEPT  = 2'd2;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [1:0]       st  [WIDTH];
    logic [WIDTH-1:0] changed_nxt;

    // Bit state is decoded from registered values only; no stored state beyond cnt.
    always_comb begin
        changed_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            st[i] = ST_IDLE;
            if (s2[i] != sw_db[i]) begin
                st[i] = (cnt[i] == CNT_LAST) ? ST_ACCEPT : ST_PENDING;
            end
            changed_nxt[i] = (st[i] == ST_ACCEPT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            sw_db       <= '0;
            changed     <= '0;
            any_changed <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1          <= sw_raw;
            s2          <= s1;
            changed     <= changed_nxt;
            any_changed <= |changed_nxt;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                case (st[i])
                    ST_PENDING: cnt[i] <= cnt[i] + CW'(1);
                    ST_ACCEPT: begin
                        sw_db[i] <= s2[i];
                        cnt[i]   <= '0;
                    end
                    default:    cnt[i] <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer at COUNT_MAX=4: per-cycle vector table
// followed by hand-written bounce, mid-count reset and voter sweep sequences.
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [4:0] sw_raw;
    logic [4:0] sw_db;
    logic [4:0] changed;
    logic       any_changed;

    int total = 0;
    int bad   = 0;

    switch_debouncer #(.WIDTH(5), .COUNT_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_raw      (sw_raw),
        .sw_db       (sw_db),
        .changed     (changed),
        .any_changed (any_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [4:0] raw;
        logic [4:0] db;
        logic [4:0] ch;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int unsigned n, input logic r, input logic [4:0] raw,
                                input logic [4:0] db, input logic [4:0] ch);
        vec_t v;
        v.r = r; v.raw = raw; v.db = db; v.ch = ch;
        for (int unsigned k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    function automatic logic majority(input logic [4:0] v);
        int unsigned ones = 0;
        for (int unsigned k = 0; k < 5; k++) ones += v[k];
        return ones >= 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
    task automatic cyc(input logic r, input logic [4:0] raw);
        @(negedge clk);
        rst    = r;
        sw_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [4:0] db, input logic [4:0] ch);
        check({tag, " sw_db"}, 32'(sw_db), 32'(db));
        check({tag, " changed"}, 32'(changed), 32'(ch));
        check({tag, " any_changed"}, 32'(any_changed), 32'(|ch));
    endtask

    initial begin
        int pulses;
        rst    = 1'b1;
        sw_raw = 5'b11111;

        // Reset with switches high, then release: full latency from the first free edge.
        add(3, 1'b1, 5'h1F, 5'h00, 5'h00);
        add(5, 1'b0, 5'h1F, 5'h00, 5'h00);
        add(1, 1'b0, 5'h1F, 5'h1F, 5'h1F);
        add(1, 1'b0, 5'h1F, 5'h1F, 5'h00);
        // Release all switches.
        add(5, 1'b0, 5'h00, 5'h1F, 5'h00);
        add(1, 1'b0, 5'h00, 5'h00, 5'h1F);
        add(1, 1'b0, 5'h00, 5'h00, 5'h00);
        // Step to 00101 and back.
        add(5, 1'b0, 5'h05, 5'h00, 5'h00);
        add(1, 1'b0, 5'h05, 5'h05, 5'h05);
        add(2, 1'b0, 5'h05, 5'h05, 5'h00);
        add(5, 1'b0, 5'h00, 5'h05, 5'h00);
        add(1, 1'b0, 5'h00, 5'h00, 5'h05);
        add(1, 1'b0, 5'h00, 5'h00, 5'h00);
        // 3-cycle glitch on bit 3: rejected.
        add(3, 1'b0, 5'h08, 5'h00, 5'h00);
        add(6, 1'b0, 5'h00, 5'h00, 5'h00);
        // 4-cycle pulse on bit 3: accepted, then released after its own debounce.
        add(4, 1'b0, 5'h08, 5'h00, 5'h00);
        add(1, 1'b0, 5'h00, 5'h00, 5'h00);
        add(1, 1'b0, 5'h00, 5'h08, 5'h08);
        add(3, 1'b0, 5'h00, 5'h08, 5'h00);
        add(1, 1'b0, 5'h00, 5'h00, 5'h08);
        add(2, 1'b0, 5'h00, 5'h00, 5'h00);

        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].raw);
            check_out($sformatf("vec%0d", i), vecs[i].db, vecs[i].ch);
        end

        // Bounce: bit0 toggles 1,0,1,0,1 then holds; last rise sampled at step 4.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            logic [4:0] raw;
            raw = (i >= 4 || (i % 2) == 0) ? 5'h01 : 5'h00;
            cyc(1'b0, raw);
            if (changed[0]) pulses++;
            check_out($sformatf("bounce%0d", i), (i >= 9) ? 5'h01 : 5'h00,
                      (i == 9) ? 5'h01 : 5'h00);
        end
        check("bounce pulse count", 32'(pulses), 32'd1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 5'h00);
        check_out("bounce settle", 5'h00, 5'h00);

        // Mid-count reset: counters reach 2 after step 3, rst at step 4.
        for (int i = 0; i < 4; i++) cyc(1'b0, 5'h1F);
        cyc(1'b1, 5'h1F);
        check_out("midrst asserted", 5'h00, 5'h00);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 5'h1F);
            check_out($sformatf("midrst%0d", i), (i >= 5) ? 5'h1F : 5'h00,
                      (i == 5) ? 5'h1F : 5'h00);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 5'h00);
        check_out("midrst settle", 5'h00, 5'h00);

        // Sweep 0..31 with a majority-of-five model standing in for the voter.
        for (int v = 0; v < 32; v++) begin
            logic [4:0] cur;
            logic [4:0] prev;
            cur  = 5'(v);
            prev = (v == 0) ? 5'h00 : 5'(v - 1);
            for (int i = 0; i < 20; i++) begin
                cyc(1'b0, cur);
                if (i == 4) check($sformatf("sweep%0d hold", v), 32'(sw_db), 32'(prev));
                if (i == 5) begin
                    check($sformatf("sweep%0d sw_db", v), 32'(sw_db), 32'(cur));
                    check($sformatf("sweep%0d changed", v), 32'(changed), 32'(cur ^ prev));
                    check($sformatf("sweep%0d led", v), 32'(majority(sw_db)),
                          32'((v == 7 || v == 28) ? 1 : (v == 9 || v == 17) ? 0 : majority(cur)));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Synchronises and debounces the five slide switches so the majority-of-five voter sees a clean, glitch-free vector. It sits directly upstream of the voter: raw board switches go in, and the stable vector `sw_db` drives the voter's `sw` input. Each bit has its own synchroniser and stability counter. A per-bit one-cycle strobe reports every accepted change.

## Interface
- `WIDTH`, 5: number of switch bits.
- `COUNT_MAX`, 1000000: number of consecutive cycles a synchronised bit must differ from its debounced value before it is accepted (10 ms at 100 MHz). Legal range is 2 or more.
- `CW`, `$clog2(COUNT_MAX)`: counter width. This is a derived localparam, not overridable.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `sw_raw`  input  WIDTH  asynchronous switch inputs.
- `sw_db`  output  WIDTH  debounced switch vector, registered. Feeds the voter.
- `changed`  output  WIDTH  per-bit one-cycle strobe, high in the cycle after `sw_db[i]` updates.
- `any_changed`  output  1  registered OR of the bit-change events. Coincident with `changed`.

## Operation
- Per bit `i`, the stages are: 2-flop synchroniser `s1[i]` ← `sw_raw[i]`, then `s2[i]` ← `s1[i]`. This feeds the counter `cnt[i]` (CW bits) and the register `sw_db[i]`.
- Bit state machine, evaluated every edge from registered values:
  - IDLE (`s2[i] == sw_db[i]`): `cnt[i]` ← 0, `changed[i]` ← 0.
  - PENDING (`s2[i] != sw_db[i]` and `cnt[i] < COUNT_MAX-1`): `cnt[i]` ← `cnt[i]+1`, `changed[i]` ← 0.
  - ACCEPT (`s2[i] != sw_db[i]` and `cnt[i] == COUNT_MAX-1`): `sw_db[i]` ← `s2[i]`, `cnt[i]` ← 0, `changed[i]` ← 1.
- If a bit returns to its debounced value during PENDING, its counter clears. There is no partial credit: a later change restarts from 0.
- Bits are fully independent. Any number of bits may be PENDING or ACCEPT in the same cycle.
- The counter never exceeds COUNT_MAX-1, and no wrap-around is possible.
- `any_changed` ← OR of the next-state `changed` bits, so it is high in exactly the same cycles as `changed`.

## Timing
- Reset values: `s1`, `s2`, `sw_db`, `changed` = 0; `any_changed` = 0; all `cnt` = 0.
- `rst` high at an edge forces these values regardless of the inputs, including mid-count. A pending change is discarded.
- After reset, switches already held at 1 must re-debounce from zero and appear after the full latency.
- Latency: let edge 0 be the first edge at which `s1` samples a new, steady value.
  - `s2` updates at edge 1.
  - `sw_db` updates at edge COUNT_MAX+1.
  - `changed` and `any_changed` are high for the one cycle following that edge.
- Rejection: a raw pulse whose synchronised width is at most COUNT_MAX-1 cycles never changes `sw_db` and never raises `changed`.
- Acceptance: a synchronised width of exactly COUNT_MAX cycles is accepted.
- Bounce: each return to the debounced value restarts the count. Acceptance occurs COUNT_MAX cycles after the last transition that leaves `s2` stable.
- The outputs are glitch-free registered values. `sw_db` changes only on a rising edge and only in ACCEPT.

## Test plan
Run all benches with `COUNT_MAX=4` and a 10 ns clock.
- **Reset:** hold `rst`=1 for 3 edges with `sw_raw`=5'b11111. Required: `sw_db`=0, `changed`=0, `any_changed`=0 throughout. After release, `sw_db`=5'b11111 at edge 5 after release, `changed`=5'b11111 for exactly one cycle.
- **Step:** from `sw_db`=0, set `sw_raw`=5'b00101 and hold. Required: `sw_db`=5'b00101 after edge COUNT_MAX+1=5 counted from the first sampling edge, `changed`=5'b00101 and `any_changed`=1 for one cycle, then both return to 0.
- **Glitch:** pulse `sw_raw[3]` high for 3 cycles, then low. Required: `sw_db` stays 0 and `changed` stays 0. Repeat with a 4-cycle pulse: `sw_db[3]` rises, then falls after a further 4-cycle debounce once the pulse ends.
- **Bounce:** toggle `sw_raw[0]` 1,0,1,0,1 on consecutive cycles, then hold at 1. Required: exactly one `changed[0]` pulse, 5 edges after the final 0→1 sampling edge. No intermediate output change.
- **Mid-count reset:** start a 0→1 change on all bits, assert `rst` at count 2 for one edge, keep `sw_raw` high. Required: `sw_db`=0 immediately, then the full-latency acceptance after `rst` drops.
- **Sweep with voter:** drive `sw_raw` through 0..31, holding each value for 20 cycles, with `sw_db` wired to majority_of_five. Required: `sw_db` equals each value 5 cycles after it is applied. `led`=1 exactly for values with 3 or more ones (e.g. 7→1, 9→0, 28→1, 17→0).
